// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default bus widths and the
// default ACCESS timeout used when APB_TIMEOUT_EN is defined.
package apb_pkg;

  // Encoding matches the slave side: IDLE=0, SEL=1, EN=2.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int APB_AW             = 32;
  localparam int APB_DW             = 32;
  localparam int APB_TIMEOUT_CYCLES = 16;

  // Index width for an N-entry vector, never below one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin picker. Scans last_gnt+1, last_gnt+2, ... with
// wrap-around and returns the first requesting index, both one-hot and
// encoded. Has no state; the caller owns last_gnt.
module apb_rr_arbiter
  import apb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IW      = clog2_min1(NUM_REQ)
)(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_gnt,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      gnt_idx,
  output logic               any
);

  logic [IW-1:0] idx;

  // Rotating priority scan: the first hit after last_gnt wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((int'(last_gnt) + k) % NUM_REQ);
      if (!any && req[idx]) begin
        any     = 1'b1;
        gnt_idx = idx;
      end
    end
    if (any) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/apb_rr_master.sv
// Round-robin APB master: shares one APB slave port between NUM_REQ local
// requesters. Each granted request becomes one SETUP->ACCESS transfer; reads
// return PRDATA on req_rdata together with a one-cycle req_done pulse.
// Transfers are always separated by at least one IDLE cycle.
// Optional: define APB_TIMEOUT_EN to abort an ACCESS phase that sees no
// PREADY within TIMEOUT_CYCLES cycles (req_done and req_err pulse together).
module apb_rr_master
  import apb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int AW             = APB_AW,
  parameter int DW             = APB_DW,
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
)(
  input  logic                  pclk,
  input  logic                  prst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_done,
  output logic [NUM_REQ-1:0]    req_err,
  output logic [DW-1:0]         req_rdata,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [AW-1:0]         PADDR,
  output logic [DW-1:0]         PWDATA,
  input  logic                  PREADY,
  input  logic [DW-1:0]         PRDATA
);

  localparam int IW = clog2_min1(NUM_REQ);

  apb_state_e                     state, state_n;
  logic [IW-1:0]                  last_gnt, last_n;
  logic [NUM_REQ-1:0]             gnt_oh, gnt_oh_n;
  logic                           psel_n, pen_n, pwrite_n;
  logic [AW-1:0]                  paddr_n;
  logic [DW-1:0]                  pwdata_n, rdata_n;
  logic [NUM_REQ-1:0]             done_n;

  logic [NUM_REQ-1:0][AW-1:0]     addr_v;
  logic [NUM_REQ-1:0][DW-1:0]     wdata_v;
  logic [NUM_REQ-1:0]             elig, arb_gnt;
  logic [IW-1:0]                  arb_idx;
  logic                           arb_any;

  // Flat operand buses share the packed-array layout (requester i at i*W).
  assign addr_v  = req_addr;
  assign wdata_v = req_wdata;

  // The requester being acknowledged this cycle still shows its stale req;
  // mask it so it cannot be re-granted.
  assign elig = req & ~req_done;

  apb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req      (elig),
    .last_gnt (last_gnt),
    .gnt      (arb_gnt),
    .gnt_idx  (arb_idx),
    .any      (arb_any)
  );

`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]      tcnt, tcnt_n;
  logic [NUM_REQ-1:0] err_n;
`else
  assign req_err = '0;
`endif

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    state_n  = state;
    last_n   = last_gnt;
    gnt_oh_n = gnt_oh;
    psel_n   = PSEL;
    pen_n    = PENABLE;
    pwrite_n = PWRITE;
    paddr_n  = PADDR;
    pwdata_n = PWDATA;
    rdata_n  = req_rdata;
    done_n   = '0;
`ifdef APB_TIMEOUT_EN
    err_n    = '0;
    tcnt_n   = tcnt;
`endif
    case (state)
      IDLE: begin
        if (arb_any) begin
          paddr_n  = addr_v[arb_idx];
          pwdata_n = wdata_v[arb_idx];
          pwrite_n = req_write[arb_idx];
          gnt_oh_n = arb_gnt;
          last_n   = arb_idx;
          psel_n   = 1'b1;
          pen_n    = 1'b0;
          state_n  = SETUP;
        end
      end
      SETUP: begin
        pen_n   = 1'b1;
        state_n = ACCESS;
`ifdef APB_TIMEOUT_EN
        tcnt_n  = '0;
`endif
      end
      ACCESS: begin
        if (PREADY) begin
          psel_n  = 1'b0;
          pen_n   = 1'b0;
          done_n  = gnt_oh;
          if (!PWRITE) rdata_n = PRDATA;
          state_n = IDLE;
        end
`ifdef APB_TIMEOUT_EN
        else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          psel_n  = 1'b0;
          pen_n   = 1'b0;
          done_n  = gnt_oh;
          err_n   = gnt_oh;
          state_n = IDLE;
        end else begin
          tcnt_n  = tcnt + 1'b1;
        end
`endif
      end
      default: begin
        psel_n  = 1'b0;
        pen_n   = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops the bus immediately.
  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      state     <= IDLE;
      last_gnt  <= IW'(NUM_REQ - 1);
      gnt_oh    <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      req_done  <= '0;
      req_rdata <= '0;
    end else begin
      state     <= state_n;
      last_gnt  <= last_n;
      gnt_oh    <= gnt_oh_n;
      PSEL      <= psel_n;
      PENABLE   <= pen_n;
      PWRITE    <= pwrite_n;
      PADDR     <= paddr_n;
      PWDATA    <= pwdata_n;
      req_done  <= done_n;
      req_rdata <= rdata_n;
    end
  end

`ifdef APB_TIMEOUT_EN
  // ACCESS-phase watchdog counter and error pulse.
  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      tcnt    <= '0;
      req_err <= '0;
    end else begin
      tcnt    <= tcnt_n;
      req_err <= err_n;
    end
  end
`endif

endmodule

// File: tb/tb_apb_rr_master.sv
// Scoreboard bench for apb_rr_master: requests push their expected outcome
// into per-requester queues; a negedge monitor checks grant order, bus
// phases, latency and completions against those queues.
module tb_apb_rr_master;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            pclk = 1'b0;
  logic            prst;
  logic [N-1:0]    req, req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_done, req_err;
  logic [DW-1:0]   req_rdata;
  logic            PSEL, PENABLE, PWRITE;
  logic [AW-1:0]   PADDR;
  logic [DW-1:0]   PWDATA, PRDATA;
  logic            PREADY = 1'b0;

  always #5 pclk = ~pclk;

  apb_rr_master #(.NUM_REQ(N), .AW(AW), .DW(DW)) dut (
    .pclk(pclk), .prst(prst), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_done(req_done),
    .req_err(req_err), .req_rdata(req_rdata), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(PREADY),
    .PRDATA(PRDATA)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- slave model ----------------
  bit scr = 1'b0;
  int force_waits = 0;
  int waits_left, cur_waits;

  function automatic logic [31:0] slave_data(input bit s, input logic [31:0] a);
    return s ? ({a[15:0], a[31:16]} ^ 32'hC3C3_3C3C) : a;
  endfunction

  assign PRDATA = slave_data(scr, PADDR);

  // PREADY is random outside ACCESS (must be ignored), scheduled inside it.
  always @(posedge pclk) begin
    #1;
    if (PSEL && !PENABLE) begin
      waits_left = (force_waits >= 0) ? force_waits : int'($urandom_range(0, 3));
      cur_waits  = waits_left;
      PREADY     = 1'($urandom_range(0, 1));
    end else if (PSEL && PENABLE) begin
      PREADY = (waits_left == 0);
      if (waits_left > 0) waits_left--;
    end else begin
      PREADY = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- scoreboard / reference ----------------
  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t        exp_q[N][$];
  logic [31:0] model_rdata;

  function automatic int rr_pick(input int last, input logic [N-1:0] e);
    for (int k = 1; k <= N; k++) begin
      if (e[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  logic     psel_q;
  logic [N-1:0] elig_prev;
  int       model_last, model_gnt, cyc, grant_cyc, pick;
  txn_t     t;

  always @(negedge pclk) begin
    cyc++;
    if (!prst) begin
      psel_q      = 1'b0;
      elig_prev   = '0;
      model_last  = N - 1;
      model_rdata = '0;
      for (int i = 0; i < N; i++) exp_q[i].delete();
    end else begin
      if (req_done != '0) begin
        chk("done_onehot", 64'($onehot(req_done)), 64'd1);
        chk("done_idx", 64'(req_done), 64'(1) << model_gnt);
        chk("done_latency", 64'(cyc - grant_cyc), 64'(2 + cur_waits));
        chk("err_zero", 64'(req_err), 64'd0);
        if (exp_q[model_gnt].size() == 0) begin
          chk("done_unexpected", 64'(req_done), 64'd0);
        end else begin
          t = exp_q[model_gnt].pop_front();
          if (t.wr) chk("wr_rdata_hold", 64'(req_rdata), 64'(model_rdata));
          else begin
            chk("rd_data", 64'(req_rdata), 64'(t.rdata));
            model_rdata = t.rdata;
          end
        end
      end else begin
        chk("err_idle", 64'(req_err), 64'd0);
      end
      if (!psel_q) begin
        pick = rr_pick(model_last, elig_prev);
        chk("grant_when_eligible", 64'(PSEL), 64'(pick >= 0));
        if (PSEL && pick >= 0) begin
          model_gnt  = pick;
          model_last = pick;
          grant_cyc  = cyc;
          chk("setup_penable", 64'(PENABLE), 64'd0);
          if (exp_q[pick].size() == 0) chk("grant_unrequested", 64'(pick), 64'(N));
          else begin
            t = exp_q[pick][0];
            chk("grant_addr", 64'(PADDR), 64'(t.addr));
            chk("grant_write", 64'(PWRITE), 64'(t.wr));
            chk("grant_wdata", 64'(PWDATA), 64'(t.wdata));
          end
        end
      end else if (PSEL) begin
        chk("access_penable", 64'(PENABLE), 64'd1);
        if (exp_q[model_gnt].size() != 0) begin
          t = exp_q[model_gnt][0];
          chk("hold_addr", 64'(PADDR), 64'(t.addr));
          chk("hold_wdata", 64'(PWDATA), 64'(t.wdata));
          chk("hold_write", 64'(PWRITE), 64'(t.wr));
        end
      end
      psel_q    = PSEL;
      elig_prev = req & ~req_done;
    end
  end

  // ---------------- requesters ----------------
  logic [N-1:0] active, drop_next;
  bit rand_en = 1'b0;

  task automatic issue(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d);
    txn_t x;
    req_write[i]        = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req[i]    = 1'b1;
    active[i] = 1'b1;
    x.wr = wr; x.addr = a; x.wdata = d; x.rdata = slave_data(scr, a);
    exp_q[i].push_back(x);
  endtask

  // One clock: requesters drop req on done (sometimes one cycle late, which
  // exercises the stale-req mask) and optionally raise new random requests.
  task automatic cyc_step();
    @(posedge pclk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (active[i] && req_done[i]) begin
        active[i] = 1'b0;
        if ($urandom_range(0, 1) == 1) drop_next[i] = 1'b1;
        else req[i] = 1'b0;
      end else if (drop_next[i]) begin
        drop_next[i] = 1'b0;
        req[i]       = 1'b0;
      end else if (rand_en && !active[i] && !req[i] && $urandom_range(0, 3) == 0) begin
        issue(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
      end
    end
  endtask

  task automatic wait_quiet(input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      if (active == '0 && drop_next == '0 && !PSEL) ok = 1'b1;
      else cyc_step();
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: still busy after 400 cycles, active=%0h", name, active);
    end
    repeat (2) cyc_step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    prst = 1'b0; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    active = '0; drop_next = '0;
    repeat (2) @(posedge pclk);
    #1;
    chk("rst_psel", 64'(PSEL), 64'd0);
    chk("rst_penable", 64'(PENABLE), 64'd0);
    chk("rst_pwrite", 64'(PWRITE), 64'd0);
    chk("rst_paddr", 64'(PADDR), 64'd0);
    chk("rst_pwdata", 64'(PWDATA), 64'd0);
    chk("rst_done_err", 64'({req_done, req_err}), 64'd0);
    chk("rst_rdata", 64'(req_rdata), 64'd0);
    prst = 1'b1;

    // Single read, zero-wait, slave echoes address.
    cyc_step();
    issue(0, 1'b0, 32'h0000_0040, 32'h0);
    wait_quiet("single_read");
    chk("single_read_data", 64'(req_rdata), 64'h40);

    // Single write; read data must stay from the previous read.
    issue(2, 1'b1, 32'h10, 32'hDEAD_BEEF);
    wait_quiet("single_write");
    chk("write_keeps_rdata", 64'(req_rdata), 64'h40);

    // Contention: all four, then 0 and 3.
    for (int i = 0; i < N; i++) issue(i, i[0], 32'h100 + 32'(i * 4), 32'hA000 + 32'(i));
    wait_quiet("contention_all");
    issue(0, 1'b0, 32'h200, 32'h0);
    issue(3, 1'b1, 32'h300, 32'h3333);
    wait_quiet("contention_1001");

    // Wait states: 5 cycles, then 20 (no abort in the default build).
    force_waits = 5;
    issue(1, 1'b1, 32'h44, 32'h1234_5678);
    wait_quiet("wait5");
    force_waits = 20;
    issue(2, 1'b0, 32'h88, 32'h0);
    wait_quiet("wait20");

    // Reset in the middle of ACCESS.
    force_waits = 50;
    issue(3, 1'b0, 32'hCC, 32'h0);
    for (int k = 0; k < 10 && !(PSEL && PENABLE); k++) cyc_step();
    chk("reached_access", 64'(PSEL && PENABLE), 64'd1);
    #2;
    prst = 1'b0;
    #1;
    chk("async_rst_psel", 64'(PSEL), 64'd0);
    chk("async_rst_penable", 64'(PENABLE), 64'd0);
    chk("async_rst_done", 64'(req_done), 64'd0);
    req = '0; active = '0; drop_next = '0;
    repeat (2) @(posedge pclk);
    #1;
    prst = 1'b1;
    force_waits = 0;
    cyc_step();
    issue(1, 1'b0, 32'h0000_1111, 32'h0);
    issue(0, 1'b0, 32'h0000_2222, 32'h0);
    wait_quiet("after_reset");

    // Randomized traffic with random wait states and scrambled read data.
    scr = 1'b1;
    force_waits = -1;
    rand_en = 1'b1;
    repeat (3000) cyc_step();
    rand_en = 1'b0;
    wait_quiet("drain");

    for (int i = 0; i < N; i++) chk("queue_empty", 64'(exp_q[i].size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apb_rr_master.md
Name: apb_rr_master

Overview:
- Round-robin arbiter plus APB master sequencer: shares one APB slave port (apbslave and its successors) between NUM_REQ local requesters.
- Accepts a simple req/done handshake per requester and converts each request into one compliant APB SETUP→ACCESS transfer.
- Captures PRDATA for reads and returns it to the requester.
- Sits between the testbench/CPU-side agents and the APB slave, on pclk.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- AW, 32, address width
- DW, 32, data width
- TIMEOUT_CYCLES, 16, ACCESS-phase cycles before abort (used only with APB_TIMEOUT_EN)

Ports:
- pclk  in  1  APB clock, all logic on rising edge
- prst  in  1  asynchronous reset, active-low (prst=0 resets)
- req  in  NUM_REQ  per-requester transfer request, level
- req_write  in  NUM_REQ  1=write, 0=read, per requester
- req_addr  in  NUM_REQ*AW  packed addresses, requester i at [i*AW +: AW]
- req_wdata  in  NUM_REQ*DW  packed write data, same packing
- req_done  out  NUM_REQ  one-cycle completion pulse, one-hot
- req_err  out  NUM_REQ  one-cycle error pulse, coincident with req_done
- req_rdata  out  DW  read data, valid while req_done is high for a read
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  AW  APB address
- PWDATA  out  DW  APB write data
- PREADY  in  1  APB ready from slave
- PRDATA  in  DW  APB read data

Behaviour:
- Reset (prst low, asynchronous):
  - State goes to IDLE.
  - All outputs are 0: PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_done, req_err, req_rdata.
  - Round-robin pointer last_gnt = NUM_REQ-1, so requester 0 has first priority.
- All outputs are registered.
- FSM states:
  - IDLE: req_done and req_err are 0 except for the completion pulse. If any eligible req is high, pick the first eligible index scanning last_gnt+1, last_gnt+2, ... with wrap-around. Latch that requester's addr, wdata and write into PADDR, PWDATA and PWRITE. Set PSEL=1, PENABLE=0, last_gnt=index, and go to SETUP.
  - SETUP: unconditionally set PENABLE=1 and go to ACCESS. PADDR, PWRITE and PWDATA stay stable.
  - ACCESS: hold all APB outputs stable until PREADY=1 is sampled. On PREADY, drop PSEL and PENABLE, pulse req_done[gnt] for one cycle, load req_rdata=PRDATA if the transfer was a read (unchanged for writes), and go to IDLE.
- No back-to-back transfers: at least one IDLE cycle always separates transfers. PSEL is low for at least one cycle.
- Eligibility: req[i] is high, and requester i is not the one whose req_done is high in the current cycle. This masks the stale req the cycle after completion.
- Requester rules:
  - Hold req and operands stable until req_done.
  - Operands are latched at grant; later changes are ignored.
  - Dropping req after grant does not abort: the transfer completes and req_done still pulses.
- Latency, zero-wait slave:
  - req high before edge k, in IDLE.
  - PSEL=1 after edge k.
  - PENABLE=1 after edge k+1.
  - PREADY sampled at edge k+2.
  - req_done=1 during cycle k+2..k+3.
  - Total: 3 cycles request-to-done. Each PREADY wait cycle adds 1.
- Simultaneous requests: exactly one grant, round-robin. No requester is starved; worst-case wait is NUM_REQ-1 transfers.
- PREADY high in IDLE or SETUP is ignored.
- Reset mid-transfer: the bus returns to idle immediately (asynchronously). The pending transfer gets no req_done.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- With the macro defined:
  - A counter runs in ACCESS and is cleared on entry.
  - If PREADY has not been seen after TIMEOUT_CYCLES ACCESS cycles, drop PSEL and PENABLE and return to IDLE.
  - Pulse req_done[gnt] and req_err[gnt] together.
  - req_rdata is unchanged.
- Without the macro: ACCESS waits on PREADY indefinitely, no counter logic exists, and req_err is tied to 0.

Decomposition:
- Shared package apb_pkg:
  - State enum (IDLE, SETUP, ACCESS) as a 2-bit encoding matching the slave's IDLE=0, SEL=1, EN=2.
  - Default AW and DW constants.
  - TIMEOUT_CYCLES default.
- One sub-module: apb_rr_arbiter.
  - Combinational round-robin picker.
  - Inputs: masked req vector, last_gnt.
  - Outputs: one-hot gnt and gnt index.
  - Reused by future bus arbiters.

Test Plan:
- Single read: req[0]=1, addr=0x0000_0040, zero-wait slave → PSEL edge k, PENABLE edge k+1, req_done[0] edge k+2, req_rdata=0x0000_0040 (slave echoes the address).
- Single write: req[2]=1, write=1, addr=0x10, wdata=0xDEADBEEF → PWRITE=1, PWDATA=0xDEADBEEF stable across SETUP and ACCESS, req_done[2] after 3 cycles, req_rdata unchanged.
- Contention: req=4'b1111 held, each dropped after its done → grants in order 0,1,2,3 with one IDLE cycle between transfers; then req=4'b1001 → next grant 0, then 3.
- Wait states: slave holds PREADY low for 5 ACCESS cycles → PADDR, PWDATA, PSEL, PENABLE stable, req_done after 8 cycles.
- Reset mid-ACCESS: prst low during ACCESS → PSEL and PENABLE go 0 without waiting for a clock edge, no req_done; after release, a new req[1] completes normally with requester 0 first in priority.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, PREADY never asserted → req_done[0]=req_err[0]=1 after 16 ACCESS cycles, bus idle; without the macro, the FSM stays in ACCESS.
